// File: rtl/dense_layer_ctrl.sv
// dense_layer_ctrl: sequences one dense-layer pass (activation intake, weight-row addressing, aligned MAC enables); define DENSE_LAYER_CTRL_BIAS_EN to append a bias-row MAC.
module dense_layer_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int INPUT_NODES = 100,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] weight_addr,
    output logic                  acc_clear,
    output logic                  mac_en,
    output logic [DATA_WIDTH-1:0] mac_data,
    output logic                  busy,
    output logic                  done
);
    localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(INPUT_NODES - 1);
    localparam logic [ADDR_WIDTH-1:0] NO_ROW = '1;
`ifdef DENSE_LAYER_CTRL_BIAS_EN
    localparam logic [ADDR_WIDTH-1:0] BIAS_ROW = ADDR_WIDTH'(INPUT_NODES);
    localparam logic [DATA_WIDTH-1:0] BIAS_ONE = DATA_WIDTH'(32'h3f800000);
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, BIAS, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE} state_t;
`endif
    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  drain_cnt;
    logic                  xfer;
    logic                  bias_issue;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    assign in_ready = state == RUN;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign xfer     = in_valid && in_ready;
`ifdef DENSE_LAYER_CTRL_BIAS_EN
    assign bias_issue = state == DRAIN && drain_cnt;
`else
    assign bias_issue = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next-state: start only honoured in IDLE, last transfer enters a 2-cycle drain
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = (xfer && idx == LAST) ? DRAIN : RUN;
`ifdef DENSE_LAYER_CTRL_BIAS_EN
            DRAIN:   state_nxt = drain_cnt ? BIAS : DRAIN;
            BIAS:    state_nxt = DONE;
`else
            DRAIN:   state_nxt = drain_cnt ? DONE : DRAIN;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // index, weight address and the two-stage activation pipeline aligned to the 1-cycle weight read
    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            drain_cnt   <= 1'b0;
            weight_addr <= NO_ROW;
            acc_clear   <= 1'b0;
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            mac_en      <= 1'b0;
            mac_data    <= '0;
        end else begin
            acc_clear <= state == IDLE && start;
            drain_cnt <= state == DRAIN && !drain_cnt;
            if (state == IDLE && start)
                idx <= '0;
            else if (xfer && idx != LAST)
                idx <= idx + ADDR_WIDTH'(1);
`ifdef DENSE_LAYER_CTRL_BIAS_EN
            if (xfer)
                weight_addr <= idx;
            else if (bias_issue)
                weight_addr <= BIAS_ROW;
            else if (state != RUN)
                weight_addr <= NO_ROW;
            s1_valid <= xfer || bias_issue;
            if (xfer)
                s1_data <= in_data;
            else if (bias_issue)
                s1_data <= BIAS_ONE;
`else
            if (xfer)
                weight_addr <= idx;
            else if (state != RUN)
                weight_addr <= NO_ROW;
            s1_valid <= xfer || bias_issue;
            if (xfer)
                s1_data <= in_data;
`endif
            mac_en <= s1_valid;
            if (s1_valid)
                mac_data <= s1_data;
        end
    end
endmodule

// File: tb/tb_dense_layer_ctrl.sv
// tb_dense_layer_ctrl: directed checks of dense_layer_ctrl (100-node and 1-node instances)
module tb_dense_layer_ctrl;
    localparam int N = 100;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [31:0] in_data;
    logic        in_ready, acc_clear, mac_en, busy, done;
    logic [7:0]  weight_addr;
    logic [31:0] mac_data;

    logic        start1, in_valid1;
    logic [31:0] in_data1;
    logic        in_ready1, acc_clear1, mac_en1, busy1, done1;
    logic [7:0]  weight_addr1;
    logic [31:0] mac_data1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mac_cnt = 0;
    bit mon_on = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    dense_layer_ctrl #(.DATA_WIDTH(32), .INPUT_NODES(N), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .weight_addr(weight_addr), .acc_clear(acc_clear),
        .mac_en(mac_en), .mac_data(mac_data), .busy(busy), .done(done)
    );

    dense_layer_ctrl #(.DATA_WIDTH(32), .INPUT_NODES(1), .ADDR_WIDTH(8)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .weight_addr(weight_addr1), .acc_clear(acc_clear1),
        .mac_en(mac_en1), .mac_data(mac_data1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mac_en must appear exactly two cycles after each transfer, carrying that transfer's data
    always @(negedge clk) begin
        if (mon_on) begin
            if (mac_en === 1'b1)
                mac_cnt++;
            if (q.size() > 0 && q[0].due == cyc) begin
                check("mac_en", mac_en, 1);
                check("mac_data", mac_data, q[0].data);
                void'(q.pop_front());
            end else begin
                check("mac_extra", mac_en, 0);
            end
        end
    end

    // mode 0 basic, 1 stalls, 2 start mid-pass and at done, 3 reset at transfer 40
    task automatic do_pass(input int mode);
        int         idx;
        int         base;
        logic [7:0] exp_wa;
        exp_t       e;
        base   = mac_cnt;
        idx    = 0;
        exp_wa = 8'hFF;
        start  = 1;
        step();
        start  = 0;
        check("acc_clear_first", acc_clear, 1);
        check("busy_run", busy, 1);
        for (int k = 0; idx < N; k++) begin
            if (k > 0)
                check("acc_clear_once", acc_clear, 0);
            check("in_ready_run", in_ready, 1);
            check("wa_run", weight_addr, exp_wa);
            check("done_run", done, 0);
            in_valid = (mode == 1) ? (k % 2 == 0) : 1'b1;
            in_data  = idx;
            start    = (mode == 2 && idx == 50);
            if (mode == 3 && idx == 40) begin
                reset = 1;
                while (q.size() > 0 && q[q.size()-1].due > cyc)
                    void'(q.pop_back());
                step();
                reset    = 0;
                in_valid = 0;
                check("abort_busy", busy, 0);
                check("abort_wa", weight_addr, 8'hFF);
                check("abort_ready", in_ready, 0);
                check("abort_done", done, 0);
                check("abort_clear", acc_clear, 0);
                check("abort_mac_data", mac_data, 0);
                for (int j = 0; j < 3; j++) begin
                    step();
                    check("abort_no_done", done, 0);
                    check("abort_idle", busy, 0);
                end
                check("abort_mac_cnt", mac_cnt - base, 39);
                return;
            end
            if (in_valid) begin
                e.due  = cyc + 2;
                e.data = idx;
                q.push_back(e);
                exp_wa = idx[7:0];
                idx++;
            end
            step();
        end
        in_valid = 0;
        start    = 0;
        check("drain_ready", in_ready, 0);
        check("drain_wa_last", weight_addr, N - 1);
        check("drain_busy", busy, 1);
        check("drain_done", done, 0);
        step();
        check("drain2_wa", weight_addr, 8'hFF);
        check("drain2_busy", busy, 1);
        check("drain2_done", done, 0);
        step();
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_wa", weight_addr, 8'hFF);
        if (mode == 2)
            start = 1;
        step();
        start = 0;
        check("done_once", done, 0);
        check("idle_busy", busy, 0);
        check("idle_ready", in_ready, 0);
        step();
        check("start_at_done_ignored", busy, 0);
        check("mac_total", mac_cnt - base, N);
        check("queue_empty", q.size(), 0);
    endtask

    initial begin
        reset     = 1;
        start     = 0;
        in_valid  = 0;
        in_data   = 0;
        start1    = 0;
        in_valid1 = 0;
        in_data1  = 0;
        repeat (3) step();
        check("rst_wa", weight_addr, 8'hFF);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_mac_data", mac_data, 0);
        check("rst_done", done, 0);
        check("rst_clear", acc_clear, 0);
        reset = 0;
        in_valid = 1;
        step();
        mon_on = 1;
        check("idle_ignores_valid", in_ready, 0);
        check("idle_wa", weight_addr, 8'hFF);
        in_valid = 0;
        step();

        do_pass(0);
        do_pass(1);
        do_pass(2);
        do_pass(3);
        do_pass(0);

        start1 = 1;
        step();
        start1 = 0;
        check("n1_clear", acc_clear1, 1);
        check("n1_ready", in_ready1, 1);
        in_valid1 = 1;
        in_data1  = 32'hA5A5_0001;
        step();
        in_valid1 = 0;
        check("n1_ready_drain", in_ready1, 0);
        check("n1_wa", weight_addr1, 0);
        check("n1_mac_early", mac_en1, 0);
        step();
        check("n1_mac_en", mac_en1, 1);
        check("n1_mac_data", mac_data1, 32'hA5A5_0001);
        check("n1_done_early", done1, 0);
        step();
        check("n1_done", done1, 1);
        check("n1_mac_once", mac_en1, 0);
        step();
        check("n1_done_once", done1, 0);
        check("n1_idle", busy1, 0);
        check("n1_wa_idle", weight_addr1, 8'hFF);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
